// File: rtl/binary_count_checker.sv
// rtl/binary_count_checker.sv - reference-model monitor for a binary counter's count/carry-out interface
// Optional macro BCC_FIRST_ERR_EN adds first_exp/first_obs capture of the first mismatch.
module binary_count_checker #(
    parameter int SIZE      = 8,
    parameter int ERRW      = 4,
    parameter int ERR_LIMIT = 3,
    parameter int AUTOSYNC  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init,
    input  logic            cin,
    input  logic [SIZE-1:0] count_in,
    input  logic            cout_in,
    output logic            locked,
    output logic            err,
    output logic [ERRW-1:0] err_count,
    output logic [7:0]      wrap_count,
    output logic            fault
`ifdef BCC_FIRST_ERR_EN
    ,
    output logic [SIZE-1:0] first_exp,
    output logic [SIZE-1:0] first_obs
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [SIZE-1:0] MAX_VAL = {SIZE{1'b1}};
    localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};
    localparam logic [ERRW-1:0] ERR_LIM = ERRW'(ERR_LIMIT);

    state_t          state_q, state_d;
    logic [SIZE-1:0] exp_q, exp_d;
    logic            err_q, err_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]      wrap_q, wrap_d;

    logic            model_cout;
    logic            mismatch;
    logic [ERRW-1:0] err_inc;
    logic            clear_fault;

    assign model_cout  = (exp_q == MAX_VAL) & cin;
    assign mismatch    = (count_in != exp_q) | (cout_in != model_cout);
    assign err_inc     = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + 1'b1;
    assign clear_fault = (state_q == ST_FAULT) & init;

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        wrap_d    = wrap_q;
        case (state_q)
            ST_IDLE: begin
                if (init) begin
                    exp_d   = '0;
                    state_d = ST_TRACK;
                end else if (AUTOSYNC != 0) begin
                    exp_d   = count_in + SIZE'(cin);
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK, ST_FAULT: begin
                if (init) begin
                    exp_d = '0;
                    if (state_q == ST_FAULT) begin
                        err_cnt_d = '0;
                        state_d   = ST_TRACK;
                    end
                end else if (mismatch) begin
                    // Resync to the observed value so one glitch is counted once.
                    err_d     = 1'b1;
                    err_cnt_d = err_inc;
                    exp_d     = count_in + SIZE'(cin);
                    if (err_inc >= ERR_LIM) begin
                        state_d = ST_FAULT;
                    end
                end else begin
                    exp_d = exp_q + SIZE'(cin);
                    if (cout_in) begin
                        wrap_d = wrap_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            exp_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            wrap_q    <= '0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            wrap_q    <= wrap_d;
        end
    end

`ifdef BCC_FIRST_ERR_EN
    logic            seen_q, seen_d;
    logic [SIZE-1:0] fexp_q, fexp_d;
    logic [SIZE-1:0] fobs_q, fobs_d;

    always_comb begin
        seen_d = seen_q;
        fexp_d = fexp_q;
        fobs_d = fobs_q;
        if (clear_fault) begin
            seen_d = 1'b0;
        end else if (err_d && !seen_q) begin
            seen_d = 1'b1;
            fexp_d = exp_q;
            fobs_d = count_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q <= 1'b0;
            fexp_q <= '0;
            fobs_q <= '0;
        end else begin
            seen_q <= seen_d;
            fexp_q <= fexp_d;
            fobs_q <= fobs_d;
        end
    end

    assign first_exp = fexp_q;
    assign first_obs = fobs_q;
`else
    logic unused_clear;
    assign unused_clear = clear_fault;
`endif

    assign locked     = (state_q != ST_IDLE);
    assign fault      = (state_q == ST_FAULT);
    assign err        = err_q;
    assign err_count  = err_cnt_q;
    assign wrap_count = wrap_q;

endmodule

// File: tb/tb_binary_count_checker.sv
// tb/tb_binary_count_checker.sv - directed self-checking bench for binary_count_checker
module tb_binary_count_checker;

    logic       clk = 1'b0;
    logic       rst, init, cin, cout_in;
    logic [7:0] count_in;
    logic       locked, err, fault;
    logic [3:0] err_count;
    logic [7:0] wrap_count;
`ifdef BCC_FIRST_ERR_EN
    logic [7:0] first_exp, first_obs;
`endif

    int         tests = 0;
    int         fails = 0;
    int         err_pulses = 0;
    logic [7:0] cnt = 8'h00;
    bit         glitch_en = 1'b0;
    logic [7:0] glitch_val = 8'h00;
    bit         sup_cout = 1'b0;

    always #5 clk = ~clk;

    binary_count_checker #(
        .SIZE(8), .ERRW(4), .ERR_LIMIT(3), .AUTOSYNC(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .cin        (cin),
        .count_in   (count_in),
        .cout_in    (cout_in),
        .locked     (locked),
        .err        (err),
        .err_count  (err_count),
        .wrap_count (wrap_count),
        .fault      (fault)
`ifdef BCC_FIRST_ERR_EN
        ,
        .first_exp  (first_exp),
        .first_obs  (first_obs)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of an ideal counter; glitch_en/sup_cout corrupt this cycle only.
    task automatic cyc(input logic r, input logic i, input logic c);
        rst      = r;
        init     = i;
        cin      = c;
        count_in = glitch_en ? glitch_val : cnt;
        cout_in  = sup_cout ? 1'b0 : ((count_in == 8'hFF) & c & ~i);
        @(posedge clk);
        #1;
        if (err) err_pulses++;
        cnt       = (r | i) ? 8'h00 : count_in + {7'd0, c};
        glitch_en = 1'b0;
        sup_cout  = 1'b0;
    endtask

    task automatic glitch(input logic [7:0] v);
        glitch_en  = 1'b1;
        glitch_val = v;
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; init = 1'b0; cin = 1'b0; count_in = 8'h00; cout_in = 1'b0;

        cyc(1'b1, 1'b0, 1'b0);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_errcnt", err_count, 0);
        check("rst_wrap", wrap_count, 0);
        check("rst_fault", fault, 0);
`ifdef BCC_FIRST_ERR_EN
        check("rst_fexp", first_exp, 0);
        check("rst_fobs", first_obs, 0);
`endif

        // Ideal counting for 600 cycles: two wraps.
        err_pulses = 0;
        cyc(1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 600; n++) cyc(1'b0, 1'b0, 1'b1);
        check("run_err_pulses", err_pulses, 0);
        check("run_wrap", wrap_count, 2);
        check("run_fault", fault, 0);
        check("run_locked", locked, 1);
        check("run_errcnt", err_count, 0);

        // cin toggling: 256 increments from 88 pass 255 exactly once.
        for (int n = 0; n < 512; n++) cyc(1'b0, 1'b0, (n % 2) == 0);
        check("tog_err_pulses", err_pulses, 0);
        check("tog_wrap", wrap_count, 3);
        check("tog_cnt", cnt, 88);

        // Single glitch 0x37 where 0x35 expected.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        for (int n = 0; n < 'h35; n++) cyc(1'b0, 1'b0, 1'b1);
        err_pulses = 0;
        glitch(8'h37);
        check("gl_err", err, 1);
        check("gl_errcnt", err_count, 1);
        cyc(1'b0, 1'b0, 1'b1);
        check("gl_err_pulse_end", err, 0);
        for (int n = 0; n < 10; n++) cyc(1'b0, 1'b0, 1'b1);
        check("gl_pulses", err_pulses, 1);
        check("gl_errcnt_hold", err_count, 1);
        check("gl_fault", fault, 0);

        // Suppressed carry-out at 255 -> 0.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        for (int n = 0; n < 255; n++) cyc(1'b0, 1'b0, 1'b1);
        check("sc_cnt", cnt, 8'hFF);
        sup_cout = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        check("sc_err", err, 1);
        check("sc_errcnt", err_count, 1);
        check("sc_wrap", wrap_count, 0);
        err_pulses = 0;
        for (int n = 0; n < 5; n++) cyc(1'b0, 1'b0, 1'b1);
        check("sc_after", err_pulses, 0);

        // Three glitches reach FAULT; init clears it.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            for (int n = 0; n < 10; n++) cyc(1'b0, 1'b0, 1'b1);
            glitch(cnt + 8'd2);
            check("lim_errcnt", err_count, k);
            check("lim_fault", fault, (k == 3) ? 1 : 0);
        end
        check("lim_locked", locked, 1);
        cyc(1'b0, 1'b0, 1'b1);
        glitch(cnt + 8'd3);
        check("flt_err", err, 1);
        check("flt_errcnt", err_count, 4);
        check("flt_fault", fault, 1);
        cyc(1'b0, 1'b1, 1'b1);
        check("clr_errcnt", err_count, 0);
        check("clr_fault", fault, 0);
        check("clr_locked", locked, 1);
        err_pulses = 0;
        for (int n = 0; n < 20; n++) cyc(1'b0, 1'b0, 1'b1);
        check("clr_pulses", err_pulses, 0);

        // Reset mid-count at 0x80 together with init and a glitch.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        for (int n = 0; n < 'h40; n++) cyc(1'b0, 1'b0, 1'b1);
        glitch(cnt + 8'd2);
        for (int n = 0; n < 300 && cnt != 8'h80; n++) cyc(1'b0, 1'b0, 1'b1);
        check("mid_errcnt_pre", err_count, 1);
        check("mid_cnt", cnt, 8'h80);
        glitch_en  = 1'b1;
        glitch_val = 8'h99;
        cyc(1'b1, 1'b1, 1'b1);
        check("mid_err", err, 0);
        check("mid_errcnt", err_count, 0);
        check("mid_wrap", wrap_count, 0);
        check("mid_fault", fault, 0);
        check("mid_locked", locked, 0);
        glitch(8'h55);
        check("idle_err", err, 0);
        check("idle_locked", locked, 1);
        err_pulses = 0;
        for (int n = 0; n < 5; n++) cyc(1'b0, 1'b0, 1'b1);
        check("sync_pulses", err_pulses, 0);

`ifdef BCC_FIRST_ERR_EN
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        for (int n = 0; n < 'h10; n++) cyc(1'b0, 1'b0, 1'b1);
        glitch(8'h12);
        check("fe_exp", first_exp, 8'h10);
        check("fe_obs", first_obs, 8'h12);
        for (int n = 0; n < 4; n++) cyc(1'b0, 1'b0, 1'b1);
        glitch(cnt + 8'd5);
        check("fe_exp_hold", first_exp, 8'h10);
        check("fe_obs_hold", first_obs, 8'h12);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/binary_count_checker.md
Name: binary_count_checker

Overview:
- Self-checking monitor placed on the far end of an 8-bit binary counter's output interface: clk, rst, init, cin in; count, cout out.
- Keeps its own reference model of the counter and compares the observed count and carry-out every cycle.
- Flags mismatches, counts errors and wrap events, and enters a sticky fault state after too many errors.
- Used in benches and as an on-chip health monitor beside counter instances.

Parameters:
- SIZE, 8, width of the monitored counter.
- ERRW, 4, width of the error counter (saturating).
- ERR_LIMIT, 3, error count at which FAULT is entered (1 to 2^ERRW-1).
- AUTOSYNC, 1, when 1 IDLE may lock onto the observed value without init; when 0 only init locks.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- init  input  1  same init the counter sees; counter loads 0 on the next edge.
- cin  input  1  same count-enable the counter sees.
- count_in  input  SIZE  observed counter value.
- cout_in  input  1  observed carry-out.
- locked  output  1  checker is tracking (TRACK or FAULT).
- err  output  1  one-cycle pulse, registered, for each mismatch.
- err_count  output  ERRW  saturating mismatch count.
- wrap_count  output  8  number of correct carry-outs seen, modulo 256.
- fault  output  1  sticky; high in FAULT.

Behaviour:
- Counter contract checked:
  - init → count=0 next edge.
  - else cin=1 → count+1 mod 2^SIZE.
  - cout_in must equal (count_in==2^SIZE-1) & cin & ~init in the same cycle.
- Reset (rst=1 at edge): state IDLE, expected=0, locked=0, err=0, err_count=0, wrap_count=0, fault=0. rst overrides all other inputs.
- IDLE:
  - init=1 → expected<=0, go TRACK.
  - else if AUTOSYNC=1 → expected<=count_in+cin (mod 2^SIZE), go TRACK.
  - No comparisons occur in IDLE.
- TRACK, each edge:
  - If init=1: expected<=0; no comparison this cycle; no error.
  - Else compare count_in vs expected and cout_in vs the modelled cout.
  - Any mismatch: err<=1 for exactly one cycle; err_count+1, saturating at 2^ERRW-1; expected<=count_in+cin (resync), so one fault is counted once.
  - Match: expected<=expected+cin; if cout_in=1, wrap_count+1 (wraps 255→0).
  - If err_count reaches ERR_LIMIT on this edge → go FAULT.
- FAULT:
  - fault=1, locked=1. Comparisons and err pulses continue; err_count still saturates.
  - init=1 → err_count<=0, fault<=0, expected<=0, go TRACK.
- Latency: values sampled at edge N produce err/err_count/wrap_count updates visible after edge N (one cycle).
- Wrap boundary: expected 2^SIZE-1 with cin=1 → next expected 0, and cout_in=1 is required that cycle.
- cin=0: expected holds; cout_in must be 0.
- Reset mid-operation: everything returns to reset values on the next edge; the first post-reset cycle is IDLE.

Optional Feature:
- Macro BCC_FIRST_ERR_EN.
- Defined: adds outputs first_exp[SIZE-1:0] and first_obs[SIZE-1:0], reset to 0. They capture expected and count_in on the first mismatch after reset or after an init-clear from FAULT, and hold until the next reset or clear.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- rst 1 cycle, init 1 cycle, cin=1, ideal counter for 600 cycles → err never 1, wrap_count=2, fault=0, locked=1.
- Ideal counter, cin toggled 1/0 each cycle → count advances every other edge, err=0, cout_in accepted only on the cin=1 cycle at 255.
- Force count_in=0x37 when expected 0x35 (single glitch, counter continues from 0x38) → one err pulse, err_count=1, no further errors.
- Suppress cout_in at 255→0 → err pulse, err_count=1, wrap_count unchanged.
- Three separate injected glitches with ERR_LIMIT=3 → fault=1 after the third; then init → fault=0, err_count=0, TRACK resumes with no error.
- rst asserted mid-count at 0x80 together with init and a glitch → all outputs 0, IDLE next cycle, no err pulse. With BCC_FIRST_ERR_EN, a glitch of expected 0x10 / observed 0x12 → first_exp=0x10, first_obs=0x12, unchanged by later glitches.
